// File: rtl/rd_popcount_if.sv
// Valid/ready stream bundle for the pipelined population counter.
// The bench drives the master side and the counter sits on the slave side.
interface rd_popcount_if #(
   parameter int WIDTH = 8,
   parameter int ACC_W = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             in_last;
   logic             mode;
   logic [ACC_W-1:0] thresh;
   logic             out_valid;
   logic             out_ready;
   logic [ACC_W-1:0] out_count;
   logic             out_ge;
   logic             out_sat;

   modport master (
      output in_valid, in_data, in_last, mode, thresh, out_ready,
      input  in_ready, out_valid, out_count, out_ge, out_sat
   );

   modport slave (
      input  in_valid, in_data, in_last, mode, thresh, out_ready,
      output in_ready, out_valid, out_count, out_ge, out_sat
   );
endinterface

// File: rtl/rd_popcount_pipe.sv
// Two-stage population counter with per-word or per-frame (saturating) results
// and a threshold compare, delivered over a valid/ready stream.
module rd_popcount_pipe #(
   parameter int WIDTH = 8,
   parameter int ACC_W = 16,
   parameter int CHUNK = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   rd_popcount_if.slave  bus
);
   localparam int CNT_W  = $clog2(WIDTH + 1);
   localparam int NCHUNK = (WIDTH + CHUNK - 1) / CHUNK;
   localparam int PW     = $clog2(CHUNK + 1);
   localparam int PAD_W  = NCHUNK * CHUNK;
   localparam logic [ACC_W-1:0] ACC_MAX = '1;

   function automatic logic [PW-1:0] chunk_count(input logic [CHUNK-1:0] c);
      logic [PW-1:0] r;
      r = '0;
      for (int i = 0; i < CHUNK; i++) r = r + PW'(c[i]);
      return r;
   endfunction

   // MSB of the result flags that the sum was clamped.
   function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] a,
                                              input logic [CNT_W-1:0] b);
      logic [ACC_W:0] s;
      s = {1'b0, a} + (ACC_W + 1)'(b);
      if (s[ACC_W]) return {1'b1, ACC_MAX};
      return s;
   endfunction

   logic                      en;
   logic                      accept;
   logic                      eff_mode;
   logic [PAD_W-1:0]          data_pad;
   logic [NCHUNK-1:0][PW-1:0] part_c;

   logic                      frame_active;
   logic                      mode_lat;

   logic                      vld_p1;
   logic [NCHUNK-1:0][PW-1:0] part_p1;
   logic                      last_p1;
   logic                      mode_p1;
   logic [ACC_W-1:0]          thresh_p1;

   logic [CNT_W-1:0]          cnt_c;
   logic [ACC_W:0]            acc_sum_c;
   logic                      sat_next_c;
   logic [ACC_W-1:0]          res_c;
   logic                      emit_c;

   logic [ACC_W-1:0]          acc;
   logic                      sat_flag;
   logic                      out_valid_p2;
   logic [ACC_W-1:0]          out_count_p2;
   logic                      out_ge_p2;
   logic                      out_sat_p2;

   assign en       = ~out_valid_p2 | bus.out_ready;
   assign accept   = bus.in_valid & en;
   assign eff_mode = frame_active ? mode_lat : bus.mode;
   assign data_pad = PAD_W'(bus.in_data);

   always_comb begin
      part_c = '0;
      for (int i = 0; i < NCHUNK; i++) part_c[i] = chunk_count(data_pad[i*CHUNK +: CHUNK]);
   end

   // Stage 1: partial counts and beat attributes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p1       <= 1'b0;
         frame_active <= 1'b0;
         mode_lat     <= 1'b0;
      end else if (en) begin
         vld_p1 <= accept;
         if (accept) begin
            mode_lat     <= eff_mode;
            frame_active <= eff_mode & ~bus.in_last;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         part_p1   <= part_c;
         last_p1   <= bus.in_last;
         mode_p1   <= eff_mode;
         thresh_p1 <= bus.thresh;
      end
   end

   always_comb begin
      cnt_c = '0;
      for (int i = 0; i < NCHUNK; i++) cnt_c = cnt_c + CNT_W'(part_p1[i]);
      acc_sum_c  = sat_add(acc, cnt_c);
      sat_next_c = sat_flag | acc_sum_c[ACC_W];
      res_c      = mode_p1 ? acc_sum_c[ACC_W-1:0] : ACC_W'(cnt_c);
      emit_c     = ~mode_p1 | last_p1;
   end

   // Stage 2: final sum, accumulator update and registered result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc          <= '0;
         sat_flag     <= 1'b0;
         out_valid_p2 <= 1'b0;
         out_count_p2 <= '0;
         out_ge_p2    <= 1'b0;
         out_sat_p2   <= 1'b0;
      end else if (en) begin
         out_valid_p2 <= vld_p1 & emit_c;
         if (vld_p1) begin
            if (emit_c) begin
               out_count_p2 <= res_c;
               out_ge_p2    <= (res_c >= thresh_p1);
               out_sat_p2   <= mode_p1 & sat_next_c;
            end
            if (mode_p1) begin
               if (last_p1) begin
                  acc      <= '0;
                  sat_flag <= 1'b0;
               end else begin
                  acc      <= acc_sum_c[ACC_W-1:0];
                  sat_flag <= sat_next_c;
               end
            end
         end
      end
   end

   assign bus.in_ready  = en;
   assign bus.out_valid = out_valid_p2;
   assign bus.out_count = out_count_p2;
   assign bus.out_ge    = out_ge_p2;
   assign bus.out_sat   = out_sat_p2;
endmodule

// File: tb/tb_rd_popcount_pipe.sv
// Randomised and directed bench for rd_popcount_pipe with a frame-level
// reference model and an in-order result scoreboard.
module tb_rd_popcount_pipe;
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   rd_popcount_if #(.WIDTH(8), .ACC_W(16)) bus ();
   rd_popcount_if #(.WIDTH(8), .ACC_W(5))  sbus ();

   rd_popcount_pipe #(.WIDTH(8), .ACC_W(16), .CHUNK(4)) dut   (.clk(clk), .rst_n(rst_n), .bus(bus));
   rd_popcount_pipe #(.WIDTH(8), .ACC_W(5),  .CHUNK(3)) dut_s (.clk(clk), .rst_n(rst_n), .bus(sbus));

   typedef struct {
      int cnt;
      bit ge;
      bit sat;
   } res_t;

   localparam int MAX16 = 65535;

   int   n_chk = 0;
   int   n_err = 0;
   int   n_out = 0;
   int   stall = 0;
   res_t exp_q[$];
   res_t e;
   bit   m_fa, m_fm, m_sat, em;
   int   m_acc, pc, sum;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Reference model: frame rules applied per accepted beat, results queued in order.
   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
         m_fa = 0; m_fm = 0; m_acc = 0; m_sat = 0;
      end else begin
         if (bus.out_valid && bus.out_ready) begin
            n_out++;
            if (exp_q.size() == 0) chk("spurious_out", 1, 0);
            else begin
               e = exp_q.pop_front();
               chk("sb_count", 32'(bus.out_count), e.cnt);
               chk("sb_ge", 32'(bus.out_ge), 32'(e.ge));
               chk("sb_sat", 32'(bus.out_sat), 32'(e.sat));
            end
         end
         if (bus.in_valid && bus.in_ready) begin
            pc = $countones(bus.in_data);
            em = m_fa ? m_fm : bus.mode;
            if (!em) begin
               exp_q.push_back('{pc, pc >= int'(bus.thresh), 1'b0});
            end else begin
               m_fm = 1;
               sum  = m_acc + pc;
               if (sum > MAX16) begin sum = MAX16; m_sat = 1; end
               if (bus.in_last) begin
                  exp_q.push_back('{sum, sum >= int'(bus.thresh), m_sat});
                  m_acc = 0; m_sat = 0; m_fa = 0;
               end else begin
                  m_acc = sum; m_fa = 1;
               end
            end
         end
      end
   end

   // Called at posedge+1; returns at posedge+1 after the beat is accepted.
   task automatic send(input logic [7:0] d, input logic l, input logic m, input logic [15:0] th);
      int w;
      bus.in_data = d; bus.in_last = l; bus.mode = m; bus.thresh = th;
      bus.in_valid = 1'b1;
      w = 0;
      @(negedge clk);
      while (!bus.in_ready && w < 100) begin
         @(negedge clk);
         w++;
      end
      if (w > 0) stall++;
      if (w >= 100) chk("send_timeout", 0, 1);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_main(output logic [15:0] c, output logic g, output logic s);
      int i;
      i = 0;
      @(negedge clk);
      while (!bus.out_valid && i < 50) begin
         @(negedge clk);
         i++;
      end
      if (i >= 50) chk("out_timeout", 0, 1);
      c = bus.out_count; g = bus.out_ge; s = bus.out_sat;
      @(posedge clk); #1;
   endtask

   task automatic drain();
      for (int i = 0; i < 60 && (exp_q.size() != 0 || bus.out_valid); i++) @(negedge clk);
      @(posedge clk); #1;
      chk("drain_empty", exp_q.size(), 0);
   endtask

   logic [15:0] c;
   logic        g, s;
   logic [7:0]  d [6];
   int          o0;
   logic [15:0] c0;
   bit          done;

   initial begin
      bus.in_valid = 0; bus.in_data = 0; bus.in_last = 0; bus.mode = 0;
      bus.thresh = 0; bus.out_ready = 0;
      sbus.in_valid = 0; sbus.in_data = 0; sbus.in_last = 0; sbus.mode = 0;
      sbus.thresh = 0; sbus.out_ready = 1;
      rst_n = 0;
      #12;
      chk("rst_in_ready", 32'(bus.in_ready), 1);
      chk("rst_out_valid", 32'(bus.out_valid), 0);
      chk("rst_out_count", 32'(bus.out_count), 0);
      chk("rst_out_ge", 32'(bus.out_ge), 0);
      chk("rst_out_sat", 32'(bus.out_sat), 0);
      @(posedge clk); #3 rst_n = 1;
      @(posedge clk); #1;
      bus.out_ready = 1;

      // Latency and basic WORD results
      send(8'hFF, 0, 0, 16'd4);
      @(negedge clk); chk("lat_t1_valid", 32'(bus.out_valid), 0);
      @(negedge clk); chk("lat_t2_valid", 32'(bus.out_valid), 1);
      chk("w_ff_count", 32'(bus.out_count), 8);
      chk("w_ff_ge", 32'(bus.out_ge), 1);
      chk("w_ff_sat", 32'(bus.out_sat), 0);
      @(posedge clk); #1;
      send(8'h00, 0, 0, 16'd4); wait_main(c, g, s);
      chk("w_00_count", 32'(c), 0); chk("w_00_ge", 32'(g), 0);
      send(8'hA5, 0, 0, 16'd4); wait_main(c, g, s);
      chk("w_a5_count", 32'(c), 4); chk("w_a5_ge", 32'(g), 1);

      // Exhaustive back-to-back sweep
      stall = 0; o0 = n_out;
      for (int i = 0; i < 256; i++) send(8'(i), 0, 0, 16'($urandom_range(0, 8)));
      drain();
      chk("sweep_results", 32'(n_out - o0), 256);
      chk("sweep_stalls", 32'(stall), 0);

      // ACCUM frame with ignored mid-frame mode change
      o0 = n_out;
      send(8'h0F, 0, 1, 16'd14);
      send(8'hFF, 0, 0, 16'd14);
      send(8'h01, 1, 1, 16'd14);
      wait_main(c, g, s);
      chk("acc_count", 32'(c), 13); chk("acc_ge", 32'(g), 0); chk("acc_sat", 32'(s), 0);
      drain();
      chk("acc_one_result", 32'(n_out - o0), 1);

      // Backpressure
      for (int i = 0; i < 6; i++) d[i] = 8'($urandom);
      bus.out_ready = 0; o0 = n_out;
      fork
         for (int i = 0; i < 6; i++) send(d[i], 0, 0, 16'($urandom_range(0, 8)));
         begin
            repeat (3) @(negedge clk);
            chk("bp_valid", 32'(bus.out_valid), 1);
            c0 = bus.out_count;
            chk("bp_first", 32'(c0), $countones(d[0]));
            repeat (3) begin
               @(negedge clk);
               chk("bp_hold", 32'(bus.out_count), 32'(c0));
            end
            chk("bp_in_ready", 32'(bus.in_ready), 0);
            @(posedge clk); #1;
            bus.out_ready = 1;
         end
      join
      drain();
      chk("bp_results", 32'(n_out - o0), 6);

      // Random traffic with random downstream stalls
      done = 0;
      fork
         begin
            for (int i = 0; i < 400; i++)
               send(8'($urandom), $urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)),
                    16'($urandom_range(0, 20)));
            send(8'($urandom), 1, 1, 16'($urandom_range(0, 20)));
            done = 1;
         end
         while (!done) begin
            @(posedge clk); #1;
            bus.out_ready = ($urandom_range(0, 3) != 0);
         end
      join
      bus.out_ready = 1;
      drain();

      // Asynchronous reset in the middle of a frame
      send(8'hFF, 0, 0, 16'd0); wait_main(c, g, s);
      chk("pre_rst_count", 32'(c), 8);
      send(8'hFF, 0, 1, 16'd0);
      send(8'hFF, 0, 1, 16'd0);
      #2 rst_n = 0;
      #1;
      chk("arst_valid", 32'(bus.out_valid), 0);
      chk("arst_count", 32'(bus.out_count), 0);
      chk("arst_ge", 32'(bus.out_ge), 0);
      chk("arst_in_ready", 32'(bus.in_ready), 1);
      @(negedge clk);
      @(posedge clk); #3 rst_n = 1;
      @(posedge clk); #1;
      send(8'h01, 1, 1, 16'd0); wait_main(c, g, s);
      chk("post_rst_count", 32'(c), 1); chk("post_rst_sat", 32'(s), 0);
      drain();

      // Saturation on the narrow accumulator
      sbus.mode = 1; sbus.thresh = 5'd31;
      for (int i = 0; i < 4; i++) begin
         sbus.in_data = 8'hFF; sbus.in_last = (i == 3); sbus.in_valid = 1;
         @(negedge clk);
         chk("s_in_ready", 32'(sbus.in_ready), 1);
         @(posedge clk); #1;
      end
      sbus.in_valid = 0;
      for (int i = 0; i < 20 && !sbus.out_valid; i++) @(negedge clk);
      chk("s_sat_count", 32'(sbus.out_count), 31);
      chk("s_sat_flag", 32'(sbus.out_sat), 1);
      chk("s_sat_ge", 32'(sbus.out_ge), 1);
      @(posedge clk); #1;
      sbus.in_data = 8'h03; sbus.in_last = 1; sbus.thresh = 5'd3; sbus.in_valid = 1;
      @(posedge clk); #1;
      sbus.in_valid = 0;
      for (int i = 0; i < 20 && !sbus.out_valid; i++) @(negedge clk);
      chk("s_next_count", 32'(sbus.out_count), 2);
      chk("s_next_sat", 32'(sbus.out_sat), 0);
      chk("s_next_ge", 32'(sbus.out_ge), 0);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule
